// File: rtl/pending_enc_pkg.sv
// Shared constants and types for the pending request encoder.
// Holds the index-width function, the output slot encoding and the drop counter default width.
package pending_enc_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_HOLD  = 1'b1
    } slotState_e;

    // The minimum result is 1, so a 2-input encoder still gets a 1-bit index.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit of vector, any = vector non-zero.
module lsb_priority_encoder
    import pending_enc_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]          vector,
    output logic [clog2(N)-1:0]   index,
    output logic                  any
);

    localparam int W = clog2(N);

    // Scanning from the top down lets the lowest set bit overwrite all others.
    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vector[i]) begin
                index = i[W-1:0];
            end
        end
    end

    assign any = |vector;

endmodule

// File: rtl/pending_request_encoder.sv
// Sticky pending register for N request lines, encoded one index per valid/ready handshake.
// Optional round-robin selection is enabled by defining PENDING_ENC_ROUND_ROBIN_EN.
module pending_request_encoder
    import pending_enc_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         reqIn,
    input  logic                 flush,
    input  logic                 outReady,
    output logic                 outValid,
    output logic [clog2(N)-1:0]  outIndex,
    output logic [N-1:0]         pendingOut,
    output logic [CNT_W-1:0]     dropCount
);

    localparam int W = clog2(N);

    function automatic int popCount(input logic [N-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                c++;
            end
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] cnt, input int inc);
        longint sum;
        longint maxVal;
        sum    = longint'(cnt) + longint'(inc);
        maxVal = (longint'(1) << CNT_W) - 1;
        if (sum > maxVal) begin
            sum = maxVal;
        end
        return sum[CNT_W-1:0];
    endfunction

    logic [N-1:0] pending;
    slotState_e   slotState;
    slotState_e   slotNext;
    logic [W-1:0] selIdx;
    logic         selAny;
    logic         loadSlot;
    logic         takeReq;
    logic [N-1:0] loadMask;

`ifdef PENDING_ENC_ROUND_ROBIN_EN
    logic [W-1:0] rrPtr;
    logic [N-1:0] rrMask;
    logic [N-1:0] maskedVec;
    logic [W-1:0] maskedIdx;
    logic         maskedAny;
    logic [W-1:0] fullIdx;
    logic         fullAny;

    always_comb begin
        rrMask = '0;
        for (int i = 0; i < N; i++) begin
            rrMask[i] = (i >= int'(rrPtr));
        end
    end

    assign maskedVec = pending & rrMask;

    lsb_priority_encoder #(.N(N)) uMaskedEnc (
        .vector (maskedVec),
        .index  (maskedIdx),
        .any    (maskedAny)
    );

    lsb_priority_encoder #(.N(N)) uFullEnc (
        .vector (pending),
        .index  (fullIdx),
        .any    (fullAny)
    );

    // Nothing at or above the pointer means the search wraps to the lowest set bit.
    assign selIdx = maskedAny ? maskedIdx : fullIdx;
    assign selAny = fullAny;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rrPtr <= '0;
        end else if (takeReq) begin
            rrPtr <= (int'(selIdx) == N - 1) ? '0 : selIdx + 1'b1;
        end
    end
`else
    lsb_priority_encoder #(.N(N)) uEnc (
        .vector (pending),
        .index  (selIdx),
        .any    (selAny)
    );
`endif

    // Only the registered pending bits compete; same-cycle reqIn waits one edge.
    assign loadSlot = (slotState == SLOT_EMPTY) || outReady;
    assign takeReq  = loadSlot && selAny && !flush;

    always_comb begin
        loadMask = '0;
        for (int i = 0; i < N; i++) begin
            loadMask[i] = takeReq && (selIdx == i[W-1:0]);
        end
    end

    always_comb begin
        slotNext = slotState;
        if (flush) begin
            slotNext = SLOT_EMPTY;
        end else if (loadSlot) begin
            slotNext = selAny ? SLOT_HOLD : SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slotState <= SLOT_EMPTY;
        end else begin
            slotState <= slotNext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~loadMask) | reqIn;
        end
    end

    // An empty load keeps the last index on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outIndex <= '0;
        end else if (takeReq) begin
            outIndex <= selIdx;
        end
    end

    // Requests discarded by flush are not counted as drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dropCount <= '0;
        end else if (!flush) begin
            dropCount <= satAdd(dropCount, popCount(reqIn & pending));
        end
    end

    assign outValid   = (slotState == SLOT_HOLD);
    assign pendingOut = pending;

endmodule

// File: tb/tb_pending_request_encoder.sv
// Bench for pending_request_encoder: directed vector table, corner sequences and randomized
// traffic against a behavioural model. Build with PENDING_ENC_ROUND_ROBIN_EN for round-robin.
module tb_pending_request_encoder;

    localparam int N     = 32;
    localparam int W     = 5;
    localparam int CNT_W = 2;
    localparam int MAXD  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     reqIn = '0;
    logic             flush = 1'b0;
    logic             outReady = 1'b0;
    logic             outValid;
    logic [W-1:0]     outIndex;
    logic [N-1:0]     pendingOut;
    logic [CNT_W-1:0] dropCount;

    pending_request_encoder #(.N(N), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .reqIn      (reqIn),
        .flush      (flush),
        .outReady   (outReady),
        .outValid   (outValid),
        .outIndex   (outIndex),
        .pendingOut (pendingOut),
        .dropCount  (dropCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [N-1:0] mPending;
    logic         mValid;
    int           mIdx;
    int           mDrop;
    int           mRr;

    typedef struct {
        logic [N-1:0] req;
        logic         fl;
        logic         rdy;
        logic         expValid;
        int           expIdx;
        logic [N-1:0] expPend;
        int           expDrop;
    } vec_t;

    vec_t tbl[21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int modelSelect();
`ifdef PENDING_ENC_ROUND_ROBIN_EN
        for (int k = 0; k < N; k++) begin
            int j;
            j = (mRr + k) % N;
            if (mPending[j]) return j;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (mPending[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic modelReset();
        mPending = '0;
        mValid   = 1'b0;
        mIdx     = 0;
        mDrop    = 0;
        mRr      = 0;
    endtask

    task automatic modelStep(input logic [N-1:0] req, input logic fl, input logic rdy);
        logic         load;
        int           sel;
        int           d;
        logic [N-1:0] nextP;
        load = !mValid || rdy;
        if (fl) begin
            mPending = '0;
            mValid   = 1'b0;
        end else begin
            sel   = modelSelect();
            d     = $countones(req & mPending);
            nextP = mPending;
            if (load) begin
                if (sel >= 0) begin
                    mValid     = 1'b1;
                    mIdx       = sel;
                    nextP[sel] = 1'b0;
                    mRr        = (sel + 1) % N;
                end else begin
                    mValid = 1'b0;
                end
            end
            mPending = nextP | req;
            mDrop    = (mDrop + d > MAXD) ? MAXD : mDrop + d;
        end
    endtask

    task automatic compareModel(input string tag);
        check({tag, ".outValid"},   64'(outValid),   64'(mValid));
        check({tag, ".outIndex"},   64'(outIndex),   64'(mIdx));
        check({tag, ".pendingOut"}, 64'(pendingOut), 64'(mPending));
        check({tag, ".dropCount"},  64'(dropCount),  64'(mDrop));
    endtask

    task automatic cycleModel(input logic [N-1:0] req, input logic fl, input logic rdy, input string tag);
        reqIn    = req;
        flush    = fl;
        outReady = rdy;
        modelStep(req, fl, rdy);
        @(posedge clk);
        #1;
        compareModel(tag);
    endtask

    task automatic applyReset();
        reset    = 1'b1;
        reqIn    = '0;
        flush    = 1'b0;
        outReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic setRow(input int i, input logic [N-1:0] req, input logic fl, input logic rdy,
                          input logic v, input int idx, input logic [N-1:0] p, input int d);
        tbl[i].req      = req;
        tbl[i].fl       = fl;
        tbl[i].rdy      = rdy;
        tbl[i].expValid = v;
        tbl[i].expIdx   = idx;
        tbl[i].expPend  = p;
        tbl[i].expDrop  = d;
    endtask

    initial begin
        // Single request: visible two edges after the pulse
        setRow(0,  32'h0000_0001, 0, 1, 0, 0,  32'h0000_0001, 0);
        setRow(1,  32'h0000_0000, 0, 1, 1, 0,  32'h0000_0000, 0);
        setRow(2,  32'h0000_0000, 0, 1, 0, 0,  32'h0000_0000, 0);
        // Two simultaneous requests drain back to back
        setRow(3,  32'h8000_0010, 0, 1, 0, 0,  32'h8000_0010, 0);
        setRow(4,  32'h0000_0000, 0, 1, 1, 4,  32'h8000_0000, 0);
        setRow(5,  32'h0000_0000, 0, 1, 1, 31, 32'h0000_0000, 0);
        setRow(6,  32'h0000_0000, 0, 1, 0, 31, 32'h0000_0000, 0);
        // Re-request of the held index, then a true drop
        setRow(7,  32'h0000_0010, 0, 0, 0, 31, 32'h0000_0010, 0);
        setRow(8,  32'h0000_0000, 0, 0, 1, 4,  32'h0000_0000, 0);
        setRow(9,  32'h0000_0010, 0, 0, 1, 4,  32'h0000_0010, 0);
        setRow(10, 32'h0000_0010, 0, 0, 1, 4,  32'h0000_0010, 1);
        setRow(11, 32'h0000_0000, 0, 1, 1, 4,  32'h0000_0000, 1);
        setRow(12, 32'h0000_0000, 0, 1, 0, 4,  32'h0000_0000, 1);
        // Drop counter saturation at 3
        setRow(13, 32'h0000_0300, 0, 0, 0, 4,  32'h0000_0300, 1);
        setRow(14, 32'h0000_0000, 0, 0, 1, 8,  32'h0000_0200, 1);
        setRow(15, 32'h0000_0200, 0, 0, 1, 8,  32'h0000_0200, 2);
        setRow(16, 32'h0000_0200, 0, 0, 1, 8,  32'h0000_0200, 3);
        setRow(17, 32'h0000_0200, 0, 0, 1, 8,  32'h0000_0200, 3);
        setRow(18, 32'h0000_0200, 0, 0, 1, 8,  32'h0000_0200, 3);
        // Flush beats simultaneous requests and outReady
        setRow(19, 32'h0000_00FF, 1, 1, 0, 8,  32'h0000_0000, 3);
        setRow(20, 32'h0000_0000, 0, 1, 0, 8,  32'h0000_0000, 3);

        modelReset();
        @(posedge clk);
        #1;
        check("reset.outValid",   64'(outValid),   64'd0);
        check("reset.outIndex",   64'(outIndex),   64'd0);
        check("reset.pendingOut", 64'(pendingOut), 64'd0);
        check("reset.dropCount",  64'(dropCount),  64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) begin
            reqIn    = tbl[i].req;
            flush    = tbl[i].fl;
            outReady = tbl[i].rdy;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d.outValid", i),   64'(outValid),   64'(tbl[i].expValid));
            check($sformatf("tbl%0d.outIndex", i),   64'(outIndex),   64'(tbl[i].expIdx));
            check($sformatf("tbl%0d.pendingOut", i), 64'(pendingOut), 64'(tbl[i].expPend));
            check($sformatf("tbl%0d.dropCount", i),  64'(dropCount),  64'(tbl[i].expDrop));
        end

        // Selection policy with bits 1 and 3 held every cycle
        applyReset();
        reqIn    = 32'h0000_000A;
        outReady = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("policy%0d.outValid", k), 64'(outValid), 64'd1);
`ifdef PENDING_ENC_ROUND_ROBIN_EN
            check($sformatf("policy%0d.outIndex", k), 64'(outIndex), (k % 2 == 0) ? 64'd1 : 64'd3);
`else
            check($sformatf("policy%0d.outIndex", k), 64'(outIndex), 64'd1);
`endif
        end

        // Asynchronous reset while a request is held
        applyReset();
        cycleModel(32'h0000_0040, 0, 0, "areset.load");
        cycleModel(32'h0000_0100, 0, 0, "areset.hold");
        #2;
        reset = 1'b1;
        #1;
        check("areset.outValid",   64'(outValid),   64'd0);
        check("areset.pendingOut", 64'(pendingOut), 64'd0);
        check("areset.outIndex",   64'(outIndex),   64'd0);
        reset = 1'b0;
        modelReset();
        cycleModel(32'h0000_0000, 0, 1, "areset.after");

        // Randomized traffic against the model
        applyReset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r;
            logic         f;
            logic         rd;
            r  = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) r = '0;
            f  = ($urandom_range(0, 31) == 0);
            rd = ($urandom_range(0, 2) != 0);
            cycleModel(r, f, rd, $sformatf("rand%0d", c));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
